// File: rtl/iq_player_pkg.sv
// Shared types and default sizing for the I/Q sample player.
package iq_player_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } player_state_t;

  localparam int DEF_SAMPLE_W = 4;
  localparam int DEF_DEPTH    = 128;

endpackage

// File: rtl/iq_sample_ram.sv
// Sample table: synchronous write, asynchronous read, so a same-edge write
// to the read address is seen by the reader as the old contents.
module iq_sample_ram
  import iq_player_pkg::*;
#(
  parameter int SAMPLE_W = DEF_SAMPLE_W,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int ADDR_W   = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [2*SAMPLE_W-1:0] wr_data,
  input  logic [ADDR_W-1:0]     rd_addr,
  output logic [2*SAMPLE_W-1:0] rd_data
);

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  logic [2*SAMPLE_W-1:0] mem [DEPTH];

  // Addresses beyond DEPTH (non power-of-two tables) are dropped.
  always_ff @(posedge clk) begin
    if (wr_en && ({1'b0, wr_addr} < DEPTH_L)) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/iq_sample_player.sv
// Programmable I/Q sample source: plays a loadable table with a periodic eoc
// strobe, one-shot or looping, with zero or hold fill between strobes.
module iq_sample_player
  import iq_player_pkg::*;
#(
  parameter int SAMPLE_W = DEF_SAMPLE_W,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int ADDR_W   = $clog2(DEPTH),
  parameter int DIV_W    = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [SAMPLE_W-1:0] wr_i,
  input  logic [SAMPLE_W-1:0] wr_q,
  input  logic                start,
  input  logic                stop,
  input  logic                loop_en,
  input  logic                zero_fill,
  input  logic [ADDR_W:0]     length,
  input  logic [DIV_W-1:0]    period,
  output logic [SAMPLE_W-1:0] i_out,
  output logic [SAMPLE_W-1:0] q_out,
  output logic                eoc,
  output logic                wrap,
  output logic                busy,
  output logic                done,
  output logic [ADDR_W-1:0]   sample_idx
);

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE_L   = (ADDR_W + 1)'(1);

  player_state_t         state_q, state_d;
  logic [DIV_W-1:0]      div_cnt_q, div_cnt_d;
  logic [ADDR_W-1:0]     idx_q, idx_d;
  logic [ADDR_W:0]       len_q, len_d;
  logic [SAMPLE_W-1:0]   i_q, i_d, q_q, q_d;
  logic                  eoc_q, eoc_d;
  logic                  wrap_q, wrap_d;
  logic                  fin_q, fin_d;
  logic [ADDR_W:0]       eff_len;
  logic                  start_ok;
  logic                  last_sample;
  logic [2*SAMPLE_W-1:0] rd_data;

  iq_sample_ram #(
    .SAMPLE_W(SAMPLE_W),
    .DEPTH   (DEPTH),
    .ADDR_W  (ADDR_W)
  ) u_ram (
    .clk    (clk),
    .wr_en  (wr_en),
    .wr_addr(wr_addr),
    .wr_data({wr_i, wr_q}),
    .rd_addr(idx_q),
    .rd_data(rd_data)
  );

  always_comb begin
    eff_len     = (length > DEPTH_L) ? DEPTH_L : length;
    start_ok    = start && (eff_len != '0);
    last_sample = ({1'b0, idx_q} == (len_q - ONE_L));

    state_d   = state_q;
    div_cnt_d = div_cnt_q;
    idx_d     = idx_q;
    len_d     = len_q;
    i_d       = i_q;
    q_d       = q_q;
    eoc_d     = 1'b0;
    wrap_d    = 1'b0;
    fin_d     = fin_q;

    if (stop) begin
      state_d   = IDLE;
      div_cnt_d = '0;
      idx_d     = '0;
      i_d       = '0;
      q_d       = '0;
      fin_d     = 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          i_d = '0;
          q_d = '0;
          if (start_ok) begin
            state_d   = RUN;
            div_cnt_d = '0;
            idx_d     = '0;
            len_d     = eff_len;
            fin_d     = 1'b0;
          end
        end
        RUN: begin
          if (start_ok) begin
            div_cnt_d = '0;
            idx_d     = '0;
            len_d     = eff_len;
            fin_d     = 1'b0;
            if (zero_fill) begin
              i_d = '0;
              q_d = '0;
            end
          end else if (fin_q) begin
            // One-shot tail: DONE is entered one edge after the final strobe.
            state_d   = DONE;
            div_cnt_d = '0;
            idx_d     = '0;
            i_d       = '0;
            q_d       = '0;
            fin_d     = 1'b0;
          end else if (div_cnt_q == period) begin
            eoc_d      = 1'b1;
            {i_d, q_d} = rd_data;
            div_cnt_d  = '0;
            if (last_sample) begin
              idx_d = '0;
              if (loop_en) begin
                wrap_d = 1'b1;
              end else begin
                fin_d = 1'b1;
              end
            end else begin
              idx_d = idx_q + ADDR_W'(1);
            end
          end else begin
            div_cnt_d = div_cnt_q + DIV_W'(1);
            if (zero_fill) begin
              i_d = '0;
              q_d = '0;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      div_cnt_q <= '0;
      idx_q     <= '0;
      len_q     <= '0;
      i_q       <= '0;
      q_q       <= '0;
      eoc_q     <= 1'b0;
      wrap_q    <= 1'b0;
      fin_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_cnt_q <= div_cnt_d;
      idx_q     <= idx_d;
      len_q     <= len_d;
      i_q       <= i_d;
      q_q       <= q_d;
      eoc_q     <= eoc_d;
      wrap_q    <= wrap_d;
      fin_q     <= fin_d;
    end
  end

  assign i_out      = i_q;
  assign q_out      = q_q;
  assign eoc        = eoc_q;
  assign wrap       = wrap_q;
  assign busy       = (state_q == RUN);
  assign done       = (state_q == DONE);
  assign sample_idx = idx_q;

endmodule

// File: tb/tb_iq_sample_player.sv
// Self-checking bench for iq_sample_player: expected traces come from the
// playback rules (strobe every period+1 edges, entry = strobe count mod L).
module tb_iq_sample_player;

  localparam int SAMPLE_W = 4;
  localparam int DEPTH    = 128;
  localparam int ADDR_W   = 7;
  localparam int DIV_W    = 8;

  logic                clk = 1'b0;
  logic                reset_n, wr_en, start, stop, loop_en, zero_fill;
  logic [ADDR_W-1:0]   wr_addr;
  logic [SAMPLE_W-1:0] wr_i, wr_q;
  logic [ADDR_W:0]     length;
  logic [DIV_W-1:0]    period;
  logic [SAMPLE_W-1:0] i_out, q_out;
  logic                eoc, wrap, busy, done;
  logic [ADDR_W-1:0]   sample_idx;

  int checks = 0;
  int errors = 0;
  int eoc_seen = 0;
  logic [SAMPLE_W-1:0] mi [DEPTH];
  logic [SAMPLE_W-1:0] mq [DEPTH];

  always #5 clk = ~clk;

  iq_sample_player #(
    .SAMPLE_W(SAMPLE_W),
    .DEPTH   (DEPTH),
    .ADDR_W  (ADDR_W),
    .DIV_W   (DIV_W)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_i      (wr_i),
    .wr_q      (wr_q),
    .start     (start),
    .stop      (stop),
    .loop_en   (loop_en),
    .zero_fill (zero_fill),
    .length    (length),
    .period    (period),
    .i_out     (i_out),
    .q_out     (q_out),
    .eoc       (eoc),
    .wrap      (wrap),
    .busy      (busy),
    .done      (done),
    .sample_idx(sample_idx)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_entry(input int a, input logic [SAMPLE_W-1:0] vi, input logic [SAMPLE_W-1:0] vq);
    wr_en   = 1'b1;
    wr_addr = ADDR_W'(a);
    wr_i    = vi;
    wr_q    = vq;
    step();
    wr_en   = 1'b0;
    mi[a]   = vi;
    mq[a]   = vq;
  endtask

  // Starts a fresh playback (from IDLE) and checks every cycle of it.
  task automatic run_play(input int l_req, input int p, input bit lp, input bit zf, input int ncyc);
    int l_eff, ns, eidx;
    bit strobe, chk_idx;
    logic ee, ew, eb, ed;
    logic [SAMPLE_W-1:0] ei, eq;
    logic [2*SAMPLE_W+3:0] exp_v, act_v;
    l_eff = (l_req > DEPTH) ? DEPTH : l_req;
    stop = 1'b1; step(); stop = 1'b0;
    length    = (ADDR_W + 1)'(l_req);
    period    = DIV_W'(p);
    loop_en   = lp;
    zero_fill = zf;
    start = 1'b1; step(); start = 1'b0;
    checks++;
    if (busy !== 1'b1 || eoc !== 1'b0 || i_out !== '0 || q_out !== '0 || sample_idx !== '0) begin
      errors++;
      $display("FAIL start_entry: busy=%b eoc=%b i=%h q=%h idx=%0d, expected busy=1 eoc=0 i=0 q=0 idx=0",
               busy, eoc, i_out, q_out, sample_idx);
    end
    for (int c = 1; c <= ncyc; c++) begin
      step();
      ns     = c / (p + 1);
      strobe = (c % (p + 1)) == 0;
      ee = 1'b0; ew = 1'b0; eb = 1'b1; ed = 1'b0; ei = '0; eq = '0;
      chk_idx = 1'b1; eidx = 0;
      if (!lp && c > l_eff * (p + 1)) begin
        eb = 1'b0; ed = 1'b1; chk_idx = 1'b0;
      end else begin
        if (strobe) begin
          ee = 1'b1;
          ei = mi[(ns - 1) % l_eff];
          eq = mq[(ns - 1) % l_eff];
          ew = lp && (((ns - 1) % l_eff) == l_eff - 1);
        end else if (!zf && ns > 0) begin
          ei = mi[(ns - 1) % l_eff];
          eq = mq[(ns - 1) % l_eff];
        end
        eidx = ns % l_eff;
        if (!lp && ns >= l_eff) chk_idx = 1'b0;
      end
      if (eoc === 1'b1) eoc_seen++;
      exp_v = {ee, ew, eb, ed, ei, eq};
      act_v = {eoc, wrap, busy, done, i_out, q_out};
      checks++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL play_cycle L=%0d P=%0d loop=%0d zf=%0d c=%0d: {eoc,wrap,busy,done,i,q}=%b, expected %b",
                 l_eff, p, lp, zf, c, act_v, exp_v);
      end
      if (chk_idx) begin
        checks++;
        if (sample_idx !== ADDR_W'(eidx)) begin
          errors++;
          $display("FAIL sample_idx c=%0d: got %0d, expected %0d", c, sample_idx, eidx);
        end
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_i = '0; wr_q = '0;
    start = 1'b0; stop = 1'b0; loop_en = 1'b0; zero_fill = 1'b1;
    length = '0; period = '0;
    step(); step();
    checks++;
    if ({eoc, wrap, busy, done, i_out, q_out, sample_idx} !== '0) begin
      errors++;
      $display("FAIL reset_values: eoc=%b wrap=%b busy=%b done=%b i=%h q=%h idx=%0d, expected all 0",
               eoc, wrap, busy, done, i_out, q_out, sample_idx);
    end
    reset_n = 1'b1;
    step();
    checks++;
    if ({eoc, busy, done} !== 3'b000) begin
      errors++;
      $display("FAIL idle_after_reset: eoc=%b busy=%b done=%b, expected 0 0 0", eoc, busy, done);
    end
  endtask

  task automatic test_loop_ramp();
    logic [SAMPLE_W-1:0] v;
    for (int k = 0; k < 99; k++) begin
      v = SAMPLE_W'(k % 16);
      write_entry(k, v, ~v);
    end
    run_play(99, 4, 1'b1, 1'b1, 99 * 5 + 3 * 5);
  endtask

  task automatic load_random();
    for (int k = 0; k < DEPTH; k++) begin
      write_entry(k, SAMPLE_W'($urandom), SAMPLE_W'($urandom));
    end
  endtask

  task automatic test_oneshot_p0();
    run_play(3, 0, 1'b0, 1'b1, 3 + 4);
  endtask

  task automatic test_hold();
    run_play(6, 2, 1'b0, 1'b0, 6 * 3 + 3);
  endtask

  task automatic test_stop_start();
    run_play(10, 3, 1'b1, 1'b1, 13);
    start = 1'b1; stop = 1'b1; step(); start = 1'b0; stop = 1'b0;
    checks++;
    if ({eoc, wrap, busy, done, i_out, q_out, sample_idx} !== '0) begin
      errors++;
      $display("FAIL stop_wins: eoc=%b wrap=%b busy=%b done=%b i=%h q=%h idx=%0d, expected all 0",
               eoc, wrap, busy, done, i_out, q_out, sample_idx);
    end
    for (int c = 0; c < 12; c++) begin
      step();
      checks++;
      if (eoc !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL stopped_quiet c=%0d: eoc=%b busy=%b, expected 0 0", c, eoc, busy);
      end
    end
    run_play(10, 3, 1'b1, 1'b1, 8);
  endtask

  task automatic test_reset_mid();
    int p;
    for (int it = 0; it < 2; it++) begin
      p = $urandom_range(0, 6);
      run_play($urandom_range(2, DEPTH), p, 1'b1, 1'(it), 990);
      reset_n = 1'b0;
      for (int c = 0; c < 2; c++) begin
        step();
        checks++;
        if ({eoc, wrap, busy, done, i_out, q_out, sample_idx} !== '0) begin
          errors++;
          $display("FAIL reset_mid it=%0d c=%0d: eoc=%b wrap=%b busy=%b done=%b i=%h q=%h idx=%0d, expected all 0",
                   it, c, eoc, wrap, busy, done, i_out, q_out, sample_idx);
        end
      end
      reset_n = 1'b1;
      for (int c = 0; c < 10; c++) begin
        step();
        checks++;
        if (eoc !== 1'b0 || busy !== 1'b0) begin
          errors++;
          $display("FAIL idle_after_reset_mid c=%0d: eoc=%b busy=%b, expected 0 0", c, eoc, busy);
        end
      end
      run_play(12, p, 1'b1, 1'b1, 3 * (p + 1));
    end
  endtask

  task automatic test_len_zero();
    stop = 1'b1; step(); stop = 1'b0;
    length = '0; period = DIV_W'(1); loop_en = 1'b1;
    start = 1'b1; step(); start = 1'b0;
    for (int c = 0; c < 6; c++) begin
      checks++;
      if (busy !== 1'b0 || eoc !== 1'b0) begin
        errors++;
        $display("FAIL len_zero c=%0d: busy=%b eoc=%b, expected 0 0", c, busy, eoc);
      end
      step();
    end
  endtask

  task automatic test_len_clamp();
    eoc_seen = 0;
    run_play(DEPTH + 5, 0, 1'b0, 1'b1, DEPTH + 3);
    checks++;
    if (eoc_seen !== DEPTH) begin
      errors++;
      $display("FAIL len_clamp: %0d strobes, expected %0d", eoc_seen, DEPTH);
    end
  endtask

  task automatic test_rw_collision();
    logic [SAMPLE_W-1:0] old_i, old_q, new_i, new_q;
    old_i = mi[1]; old_q = mq[1];
    new_i = ~old_i; new_q = ~old_q;
    stop = 1'b1; step(); stop = 1'b0;
    length = (ADDR_W + 1)'(4); period = DIV_W'(3); loop_en = 1'b0; zero_fill = 1'b1;
    start = 1'b1; step(); start = 1'b0;
    for (int c = 1; c <= 7; c++) step();
    // Write entry 1 on the very edge that emits it.
    wr_en = 1'b1; wr_addr = ADDR_W'(1); wr_i = new_i; wr_q = new_q;
    step();
    wr_en = 1'b0;
    mi[1] = new_i; mq[1] = new_q;
    checks++;
    if (eoc !== 1'b1 || i_out !== old_i || q_out !== old_q) begin
      errors++;
      $display("FAIL rw_collision: eoc=%b i=%h q=%h, expected eoc=1 i=%h q=%h",
               eoc, i_out, q_out, old_i, old_q);
    end
    run_play(4, 1, 1'b0, 1'b1, 4 * 2 + 2);
  endtask

  initial begin
    test_reset();
    test_loop_ramp();
    load_random();
    test_oneshot_p0();
    test_hold();
    test_stop_start();
    test_reset_mid();
    test_len_zero();
    test_len_clamp();
    test_rw_collision();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
